ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: the sending side of the PS/2 link whose receive side

---
 rtl/ps2_host_tx.sv | 183 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Requests the bus (clock inhibit, then start bit), shifts out data, parity and
// stop on device clock falling edges, samples the device ACK and reports the
// result with a one-cycle tx_done / tx_err pair. rx_inhibit mirrors tx_busy so
// the neighbouring receiver ignores the bits we are sending.
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 480,
  parameter int START_CYC   = 8,
  parameter int TIMEOUT_CYC = 60000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_stb,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic       rx_inhibit,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_INHIBIT  = 3'd1;
  localparam logic [2:0] S_START    = 3'd2;
  localparam logic [2:0] S_SEND     = 3'd3;
  localparam logic [2:0] S_ACK      = 3'd4;
  localparam logic [2:0] S_WAITIDLE = 3'd5;

  localparam logic [15:0] INH_LAST   = 16'(INHIBIT_CYC - 1);
  localparam logic [15:0] START_LAST = 16'(START_CYC - 1);
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYC - 1);

  logic [2:0]  state;
  logic [9:0]  frame;
  logic [3:0]  bitcnt;
  logic [15:0] cnt;
  logic        ack_err;

  // clk_sync[1:0] is the two-flop synchronizer, clk_sync[2] the previous sample
  logic [2:0]  clk_sync;
  logic [1:0]  dat_sync;
  logic        clk_s;
  logic        dat_s;
  logic        clk_fall;
  logic        timeout;

  assign clk_s      = clk_sync[1];
  assign dat_s      = dat_sync[1];
  assign clk_fall   = clk_sync[2] & ~clk_sync[1];
  assign timeout    = (cnt == TO_LAST);
  assign rx_inhibit = tx_busy;

  // Synchronize the asynchronous pin levels; idle bus level is high
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk_i};
      dat_sync <= {dat_sync[0], ps2_dat_i};
    end
  end

  // Transfer sequencer: bus request, bit shifting, ACK check and timeout abort
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      frame      <= '0;
      bitcnt     <= '0;
      cnt        <= '0;
      ack_err    <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          if (tx_stb) begin
            frame      <= {1'b1, ~^tx_data, tx_data};
            state      <= S_INHIBIT;
            tx_busy    <= 1'b1;
            ps2_clk_oe <= 1'b1;
            cnt        <= '0;
          end
        end

        S_INHIBIT: begin
          if (cnt == INH_LAST) begin
            state      <= S_START;
            ps2_dat_oe <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_START: begin
          if (cnt == START_LAST) begin
            state      <= S_SEND;
            ps2_clk_oe <= 1'b0;
            bitcnt     <= '0;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_SEND: begin
          if (clk_fall) begin
            cnt        <= '0;
            ps2_dat_oe <= ~frame[bitcnt];
            bitcnt     <= bitcnt + 4'd1;
            if (bitcnt == 4'd9) begin
              state <= S_ACK;
            end
          end else if (timeout) begin
            state      <= S_IDLE;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b1;
            tx_err     <= 1'b1;
            ps2_dat_oe <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_ACK: begin
          if (clk_fall) begin
            cnt     <= '0;
            ack_err <= dat_s;
            state   <= S_WAITIDLE;
          end else if (timeout) begin
            state      <= S_IDLE;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b1;
            tx_err     <= 1'b1;
            ps2_dat_oe <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_WAITIDLE: begin
          // a falling edge implies clk_s is low, so the idle test cannot collide with it
          if (clk_s && dat_s) begin
            state      <= S_IDLE;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b1;
            tx_err     <= ack_err;
            ps2_dat_oe <= 1'b0;
          end else if (clk_fall) begin
            cnt <= '0;
          end else if (timeout) begin
            state      <= S_IDLE;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b1;
            tx_err     <= 1'b1;
            ps2_dat_oe <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        default: begin
          state      <= S_IDLE;
          tx_busy    <= 1'b0;
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: directed transfers against a PS/2 device model, with a
// per-cycle comparison against a timing-window model of the expected outputs.
module tb_ps2_host_tx;

  localparam int INH  = 480;
  localparam int STC  = 8;
  localparam int TO   = 3000;
  localparam int HALF = 160;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_stb = 1'b0;
  logic       tx_busy, tx_done, tx_err, rx_inhibit;
  logic       ps2_clk_i, ps2_dat_i, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  // open-drain bus: either side pulling low wins
  assign ps2_clk_i = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_i = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYC(INH),
    .START_CYC  (STC),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_stb    (tx_stb),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_err    (tx_err),
    .rx_inhibit(rx_inhibit),
    .ps2_clk_i (ps2_clk_i),
    .ps2_dat_i (ps2_dat_i),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model state
  bit         m_on = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         m_acc = 0;
  bit         m_cur = 1'b1;
  bit         m_prev = 1'b1;
  int         m_chg = 0;
  int         m_done_lo = 0;
  int         m_done_hi = 0;
  bit         m_err = 1'b0;
  int         done_cnt = 0;
  int         done_at = 0;
  bit         last_err = 1'b0;
  logic [9:0] cap = '0;
  int         cmp_n = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // expected data-line pull for the k-th device falling edge (1..10)
  function automatic bit model_oe(input int k, input logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    if (k <= 8) return !d[k-1];
    if (k == 9) return (ones % 2) != 0;   // parity bit is 1 when ones count is even
    return 1'b0;                          // stop bit: line released
  endfunction

  task automatic model_edge(input int k);
    m_prev = m_cur;
    m_cur  = model_oe(k, m_data);
    m_chg  = cyc;
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    cyc++;
    chk("rx_inhibit", int'(rx_inhibit), int'(tx_busy));
    if (tx_done) done_cnt++;
    if (!m_on) begin
      chk("idle_outputs", int'({ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done}), 0);
    end else begin
      cmp_n = cyc - m_acc;
      if (tx_done) begin
        chk("done_in_window",
            int'(m_done_hi != 0 && cyc >= m_done_lo && cyc <= m_done_hi), 1);
        chk("done_err", int'(tx_err), int'(m_err));
        chk("done_lines", int'({ps2_clk_oe, ps2_dat_oe}), 0);
        last_err = tx_err;
        done_at  = cyc;
        m_on     = 1'b0;
      end else begin
        chk("busy", int'(tx_busy), 1);
        chk("clk_oe", int'(ps2_clk_oe), int'(cmp_n <= INH + STC));
        if (cmp_n <= INH) begin
          chk("dat_oe_inhibit", int'(ps2_dat_oe), 0);
        end else if (cmp_n <= INH + STC) begin
          chk("dat_oe_start", int'(ps2_dat_oe), 1);
        end else if (cyc - m_chg <= 4) begin
          chk("dat_oe_edge", int'(ps2_dat_oe == m_cur || ps2_dat_oe == m_prev), 1);
        end else begin
          chk("dat_oe_bit", int'(ps2_dat_oe), int'(m_cur));
        end
        if (m_done_hi != 0 && cyc > m_done_hi) begin
          chk("done_missing", 0, 1);
          m_on = 1'b0;
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit exp_err);
    tx_data   = d;
    tx_stb    = 1'b1;
    m_acc     = cyc;
    m_data    = d;
    m_cur     = 1'b1;
    m_prev    = 1'b1;
    m_chg     = 0;
    m_done_lo = 0;
    m_done_hi = 0;
    m_err     = exp_err;
    m_on      = 1'b1;
    wait_cyc(1);
    tx_stb = 1'b0;
  endtask

  task automatic wait_release();
    int n;
    n = 0;
    while (ps2_clk_oe && n < INH + STC + 50) begin
      wait_cyc(1);
      n++;
    end
    chk("clock_released", int'(ps2_clk_oe), 0);
  endtask

  // device clocks nfall falling edges; edge 11 is the ACK edge
  task automatic dev_frame(input int nfall, input bit ack_low, input int stb_edge);
    for (int k = 1; k <= nfall; k++) begin
      if (k == 11) begin
        wait_cyc(HALF / 2);
        dev_dat_low = ack_low;
        wait_cyc(HALF - HALF / 2);
      end else begin
        wait_cyc(HALF);
      end
      dev_clk_low = 1'b1;
      if (k <= 10) model_edge(k);
      if (k == stb_edge) begin
        tx_data = 8'h00;
        tx_stb  = 1'b1;
      end
      wait_cyc(1);
      tx_stb = 1'b0;
      wait_cyc(HALF - 3);
      if (k <= 10) cap[k-1] = ps2_dat_oe;
      wait_cyc(2);
      dev_clk_low = 1'b0;
      if (k == 11) begin
        dev_dat_low = 1'b0;
        m_done_lo   = cyc + 1;
        m_done_hi   = cyc + 6;
      end
    end
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (m_on && n < limit) begin
      wait_cyc(1);
      n++;
    end
    if (m_on) begin
      chk("done_wait", 0, 1);
      m_on = 1'b0;
    end
  endtask

  task automatic normal_xfer(input logic [7:0] d, input bit ack_low, input int stb_edge,
                             input logic [9:0] exp_cap, input string tag);
    int base;
    base = done_cnt;
    cap  = '1;
    send(d, !ack_low);
    wait_release();
    dev_frame(11, ack_low, stb_edge);
    wait_done(100);
    chk({tag, "_wave"}, int'(cap), int'(exp_cap));
    chk({tag, "_err"}, int'(last_err), int'(!ack_low));
    wait_cyc(20);
    chk({tag, "_done_count"}, done_cnt - base, 1);
  endtask

  initial begin
    int base;
    wait_cyc(4);
    reset = 1'b0;
    wait_cyc(4);
    chk("reset_busy", int'(tx_busy), 0);
    chk("reset_lines", int'({ps2_clk_oe, ps2_dat_oe}), 0);
    chk("model_parity_F4", int'(model_oe(9, 8'hF4)), 1);
    chk("model_parity_FF", int'(model_oe(9, 8'hFF)), 0);

    // 0xF4, ACK
    normal_xfer(8'hF4, 1'b1, 0, 10'h10B, "f4");
    // 0xFF, ACK
    normal_xfer(8'hFF, 1'b1, 0, 10'h000, "ff");

    // device never clocks: timeout measured from clock release
    base = done_cnt;
    send(8'h55, 1'b1);
    m_done_lo = m_acc + INH + STC + 1 + TO;
    m_done_hi = m_done_lo;
    wait_done(TO + INH + 600);
    chk("timeout_latency", done_at - m_acc, 3489);
    chk("timeout_err", int'(last_err), 1);
    wait_cyc(20);
    chk("timeout_done_count", done_cnt - base, 1);

    // NACK
    normal_xfer(8'hF4, 1'b0, 0, 10'h10B, "nack");
    // tx_stb with 0x00 during SEND is ignored
    normal_xfer(8'hA5, 1'b1, 3, 10'h05A, "busy_stb");

    // reset after the fourth bit
    base = done_cnt;
    send(8'h07, 1'b0);
    wait_release();
    dev_frame(4, 1'b0, 0);
    chk("pre_reset_dat_oe", int'(ps2_dat_oe), 1);
    wait_cyc(10);
    reset = 1'b1;
    m_on  = 1'b0;
    wait_cyc(1);
    chk("reset_mid_lines", int'({ps2_clk_oe, ps2_dat_oe}), 0);
    chk("reset_mid_busy", int'(tx_busy), 0);
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(300);
    chk("reset_no_done", done_cnt - base, 0);
    normal_xfer(8'hF4, 1'b1, 0, 10'h10B, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
